// File: rtl/usb_recv_pkt.sv
// usb_recv_pkt
//   Packet receiver that sits after the bit destuffer and sync detector.
//   Assembles destuffed bits into a checked PID and data bytes. Data bytes are
//   queued in a byte FIFO tagged with a first-byte flag and read out through a
//   valid/ready handshake. Every packet that gets past its PID ends with a
//   one-clock status record: PID, length, CRC5/CRC16 result and error flags.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   strobe, din           one destuffed bit per strobe
//   sync, se0             sync detected / end-of-packet, sampled on strobe
//   o_data, o_first       FIFO head byte (bit0 first received), first-byte tag
//   o_valid, o_ready      FIFO read handshake
//   busy                  receiving a packet (PID, DATA or DISCARD)
//   eop_*                 end-of-packet status, eop_valid pulses for one clk
//
// State | meaning
//   IDLE    | waiting for sync
//   PID     | collecting PID byte and its check nibble
//   DATA    | collecting payload/CRC bytes into the FIFO
//   DISCARD | bad PID, ignore bits until SE0
module usb_recv_pkt #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 1026,
    parameter int LEN_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic             din,
    input  logic             sync,
    input  logic             se0,
    output logic [7:0]       o_data,
    output logic             o_first,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             busy,
    output logic             eop_valid,
    output logic [3:0]       eop_pid,
    output logic [LEN_W-1:0] eop_len,
    output logic             eop_crc5_ok,
    output logic             eop_crc16_ok,
    output logic             eop_pid_err,
    output logic             eop_align_err,
    output logic             eop_overflow,
    output logic             eop_toolong
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);
    localparam logic [4:0]       CRC5_RES  = 5'b01100;
    localparam logic [15:0]      CRC16_RES = 16'h800D;

    typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_DATA, ST_DISCARD} state_t;

    state_t             state_q, state_d;
    logic [2:0]         bcnt_q;
    logic [6:0]         shift_q;
    logic [LEN_W-1:0]   len_q;
    logic [3:0]         pid_q;
    logic               ovf_q, tl_q, c5ok_q, c16ok_q;
    logic [4:0]         crc5_q;
    logic [15:0]        crc16_q;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [8:0]         mem_q [FIFO_DEPTH];

    logic               eop_valid_q, eop_crc5_q, eop_crc16_q, eop_pid_err_q;
    logic               eop_align_q, eop_ovf_q, eop_tl_q;
    logic [3:0]         eop_pid_q;
    logic [LEN_W-1:0]   eop_len_q;

    logic [7:0]         byte_w;
    logic               bit_ev, byte_last, pid_ok, too_long, full, fifo_pop, fifo_push;
    logic               eop_emit;
    logic [LEN_W-1:0]   len_inc;
    logic [4:0]         crc5_nxt;
    logic [15:0]        crc16_nxt;

    // bits arrive LSB first, so the newest bit enters at the top
    assign byte_w    = {din, shift_q};
    assign bit_ev    = strobe && !se0;
    assign byte_last = bit_ev && (bcnt_q == 3'd7);
    assign pid_ok    = (byte_w[7:4] == ~byte_w[3:0]);
    assign len_inc   = (len_q == LEN_SAT) ? LEN_SAT : len_q + LEN_W'(1);
    assign too_long  = (len_inc > LEN_MAX);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_valid   = (wr_ptr_q != rd_ptr_q);
    assign fifo_pop  = o_valid && o_ready;
    // a pop in the same clock frees the slot, so a full FIFO still accepts
    assign fifo_push = (state_q == ST_DATA) && byte_last && !too_long && (!full || fifo_pop);
    assign eop_emit  = strobe && se0 && ((state_q == ST_DATA) || (state_q == ST_DISCARD));

    assign crc5_nxt  = {crc5_q[3:0], 1'b0}   ^ ((din ^ crc5_q[4])   ? 5'h05    : 5'h00);
    assign crc16_nxt = {crc16_q[14:0], 1'b0} ^ ((din ^ crc16_q[15]) ? 16'h8005 : 16'h0000);

    assign o_data  = mem_q[rd_ptr_q[AW-1:0]][7:0];
    assign o_first = mem_q[rd_ptr_q[AW-1:0]][8];
    assign busy    = (state_q != ST_IDLE);

    assign eop_valid     = eop_valid_q;
    assign eop_pid       = eop_pid_q;
    assign eop_len       = eop_len_q;
    assign eop_crc5_ok   = eop_crc5_q;
    assign eop_crc16_ok  = eop_crc16_q;
    assign eop_pid_err   = eop_pid_err_q;
    assign eop_align_err = eop_align_q;
    assign eop_overflow  = eop_ovf_q;
    assign eop_toolong   = eop_tl_q;

    always_comb begin
        state_d = state_q;
        if (strobe) begin
            case (state_q)
                ST_IDLE:    if (sync && !se0) state_d = ST_PID;
                ST_PID: begin
                    if (se0)            state_d = ST_IDLE;
                    else if (byte_last) state_d = pid_ok ? ST_DATA : ST_DISCARD;
                end
                ST_DATA,
                ST_DISCARD: if (se0) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= {(len_q == '0), byte_w};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q        <= '0;
            shift_q       <= '0;
            len_q         <= '0;
            pid_q         <= '0;
            ovf_q         <= 1'b0;
            tl_q          <= 1'b0;
            c5ok_q        <= 1'b0;
            c16ok_q       <= 1'b0;
            crc5_q        <= '1;
            crc16_q       <= '1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            eop_valid_q   <= 1'b0;
            eop_pid_q     <= '0;
            eop_len_q     <= '0;
            eop_crc5_q    <= 1'b0;
            eop_crc16_q   <= 1'b0;
            eop_pid_err_q <= 1'b0;
            eop_align_q   <= 1'b0;
            eop_ovf_q     <= 1'b0;
            eop_tl_q      <= 1'b0;
        end else begin
            eop_valid_q <= eop_emit;
            if (fifo_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);

            // CRC registers only run over DATA bits; anywhere else they sit at the seed
            if (state_q != ST_DATA) begin
                crc5_q  <= '1;
                crc16_q <= '1;
            end else if (bit_ev) begin
                crc5_q  <= crc5_nxt;
                crc16_q <= crc16_nxt;
            end

            if (strobe) begin
                case (state_q)
                    ST_IDLE: begin
                        if (sync && !se0) begin
                            bcnt_q  <= '0;
                            len_q   <= '0;
                            ovf_q   <= 1'b0;
                            tl_q    <= 1'b0;
                            c5ok_q  <= 1'b0;
                            c16ok_q <= 1'b0;
                        end
                    end
                    ST_PID: begin
                        if (!se0) begin
                            shift_q <= byte_w[7:1];
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7 && pid_ok) pid_q <= byte_w[3:0];
                        end
                    end
                    ST_DATA: begin
                        if (se0) begin
                            eop_pid_q     <= pid_q;
                            eop_len_q     <= len_q;
                            eop_crc5_q    <= c5ok_q;
                            eop_crc16_q   <= c16ok_q;
                            eop_pid_err_q <= 1'b0;
                            eop_align_q   <= (bcnt_q != 3'd0);
                            eop_ovf_q     <= ovf_q;
                            eop_tl_q      <= tl_q;
                        end else begin
                            shift_q <= byte_w[7:1];
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                len_q   <= len_inc;
                                c5ok_q  <= (crc5_nxt == CRC5_RES);
                                c16ok_q <= (crc16_nxt == CRC16_RES);
                                if (too_long)        tl_q  <= 1'b1;
                                else if (!fifo_push) ovf_q <= 1'b1;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (se0) begin
                            eop_pid_q     <= pid_q;
                            eop_len_q     <= '0;
                            eop_crc5_q    <= 1'b0;
                            eop_crc16_q   <= 1'b0;
                            eop_pid_err_q <= 1'b1;
                            eop_align_q   <= 1'b0;
                            eop_ovf_q     <= 1'b0;
                            eop_tl_q      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_recv_pkt.sv
// tb_usb_recv_pkt
//   Random packets (good/corrupt CRC5/CRC16 trailers, bad PIDs, PID aborts,
//   partial trailing bytes, FIFO back-pressure, over-length packets and resets
//   mid-packet) compared against a packet-level model: a byte queue for the
//   FIFO and per-packet expected status computed from the bit stream.
module tb_usb_recv_pkt;
    localparam int DEPTH = 4;
    localparam int MAXL  = 8;
    localparam int LW    = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          strobe = 1'b0, din = 1'b0, sync = 1'b0, se0 = 1'b0, o_ready = 1'b0;
    logic [7:0]    o_data;
    logic          o_first, o_valid, busy, eop_valid;
    logic [3:0]    eop_pid;
    logic [LW-1:0] eop_len;
    logic          eop_crc5_ok, eop_crc16_ok, eop_pid_err, eop_align_err, eop_overflow, eop_toolong;

    usb_recv_pkt #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .din(din), .sync(sync), .se0(se0),
        .o_data(o_data), .o_first(o_first), .o_valid(o_valid), .o_ready(o_ready),
        .busy(busy), .eop_valid(eop_valid), .eop_pid(eop_pid), .eop_len(eop_len),
        .eop_crc5_ok(eop_crc5_ok), .eop_crc16_ok(eop_crc16_ok), .eop_pid_err(eop_pid_err),
        .eop_align_err(eop_align_err), .eop_overflow(eop_overflow), .eop_toolong(eop_toolong)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q_model [$];
    bit         m_busy = 1'b0;
    int         ready_pct = 100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // LFSR remainder of the first n bits, seeded with all ones
    function automatic logic [15:0] crc_of(input bit b[$], input int n, input int w);
        logic [15:0] c;
        logic [15:0] poly;
        bit          fb;
        c    = (w == 5) ? 16'h001F : 16'hFFFF;
        poly = (w == 5) ? 16'h0005 : 16'h8005;
        for (int i = 0; i < n; i++) begin
            fb = b[i] ^ c[w-1];
            c  = c << 1;
            if (fb) c = c ^ poly;
            c = (w == 5) ? (c & 16'h001F) : c;
        end
        return c;
    endfunction

    // true when the last w of n bits are the complemented CRC of the rest, MSB first
    function automatic bit trailer_ok(input bit b[$], input int n, input int w);
        logic [15:0] c;
        if (n < w) return 1'b0;
        c = crc_of(b, n - w, w);
        for (int i = 0; i < w; i++)
            if (b[n-w+i] == c[w-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    // one clock: drive inputs, check FIFO head before the edge, update model after it
    task automatic tick(input bit s, input bit d, input bit sy, input bit e,
                        input bit push_req, input logic [8:0] pword, input bit eop_n,
                        output bit acc);
        bit rdy, pop;
        strobe = s; din = d; sync = sy; se0 = e;
        rdy = ($urandom_range(99) < ready_pct);
        o_ready = rdy;
        @(negedge clk);
        chk("o_valid", 32'(o_valid), 32'(q_model.size() != 0));
        if (q_model.size() != 0) chk("head", 32'({o_first, o_data}), 32'(q_model[0]));
        @(posedge clk);
        pop = rdy && (q_model.size() != 0);
        acc = push_req && ((q_model.size() < DEPTH) || pop);
        if (pop) void'(q_model.pop_front());
        if (acc) q_model.push_back(pword);
        #1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("eop_valid", 32'(eop_valid), 32'(eop_n));
    endtask

    task automatic gap();
        bit acc;
        int n;
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++)
            tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 9'h0, 1'b0, acc);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        q_model.delete();
        m_busy = 1'b0;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eop_valid", 32'(eop_valid), 32'd0);
        chk("rst_eop_len", 32'(eop_len), 32'd0);
        chk("rst_eop_pid", 32'(eop_pid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_packet(input int nb, input int crc_mode, input bit pid_bad,
                               input int abort_pid, input int partial, input bit flip,
                               input int rst_at);
        bit          db[$];
        bit          acc, ovf, tl, exp_c5, exp_c16, push_req;
        logic [3:0]  p;
        logic [7:0]  pb, cur;
        logic [15:0] c;
        int          len, len_new, nfull, m;

        p  = 4'($urandom);
        pb = {~p, p};
        if (pid_bad) pb[7:4] = ~p ^ 4'($urandom_range(1, 15));

        if (crc_mode == 1 && nb == 2) begin
            for (int i = 0; i < 11; i++) db.push_back(1'($urandom));
            c = crc_of(db, 11, 5);
            for (int i = 0; i < 5; i++) db.push_back(~c[4-i]);
        end else if (crc_mode == 2 && nb >= 2) begin
            m = 8 * (nb - 2);
            for (int i = 0; i < m; i++) db.push_back(1'($urandom));
            c = crc_of(db, m, 16);
            for (int i = 0; i < 16; i++) db.push_back(~c[15-i]);
        end else begin
            for (int i = 0; i < 8 * nb; i++) db.push_back(1'($urandom));
        end
        nfull = 8 * nb;
        if (flip && nfull > 0) begin
            m = $urandom_range(0, nfull - 1);
            db[m] = ~db[m];
        end
        exp_c5  = (nb >= 1) && trailer_ok(db, nfull, 5);
        exp_c16 = trailer_ok(db, nfull, 16);
        for (int i = 0; i < partial; i++) db.push_back(1'($urandom));

        m_busy = 1'b0;
        if ($urandom_range(3) == 0) tick(1'b1, 1'($urandom), 1'b1, 1'b1, 1'b0, 9'h0, 1'b0, acc);
        if ($urandom_range(3) == 0) tick(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, acc);
        if ($urandom_range(3) == 0) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0, acc);
        gap();
        m_busy = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 1'b0, acc);

        for (int i = 0; i < 8; i++) begin
            gap();
            if (i == abort_pid) begin
                m_busy = 1'b0;
                tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0, acc);
                return;
            end
            tick(1'b1, pb[i], ($urandom_range(7) == 0), 1'b0, 1'b0, 9'h0, 1'b0, acc);
        end

        len = 0; ovf = 1'b0; tl = 1'b0;
        for (int k = 0; k < db.size(); k++) begin
            gap();
            if (k == rst_at) begin
                do_reset();
                return;
            end
            if (!pid_bad && (k % 8 == 7)) begin
                for (int j = 0; j < 8; j++) cur[j] = db[k-7+j];
                len_new  = (len >= MAXL + 1) ? MAXL + 1 : len + 1;
                push_req = (len_new <= MAXL);
                tick(1'b1, db[k], ($urandom_range(7) == 0), 1'b0, push_req,
                     {(k / 8 == 0), cur}, 1'b0, acc);
                if (!push_req)   tl  = 1'b1;
                else if (!acc)   ovf = 1'b1;
                len = len_new;
            end else begin
                tick(1'b1, db[k], ($urandom_range(7) == 0), 1'b0, 1'b0, 9'h0, 1'b0, acc);
            end
        end

        gap();
        m_busy = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h0, 1'b1, acc);
        if (pid_bad) begin
            chk("pid_err", 32'(eop_pid_err), 32'd1);
            chk("len_discard", 32'(eop_len), 32'd0);
            chk("ovf_discard", 32'(eop_overflow), 32'd0);
            chk("tl_discard", 32'(eop_toolong), 32'd0);
            chk("align_discard", 32'(eop_align_err), 32'd0);
        end else begin
            chk("eop_pid", 32'(eop_pid), 32'(p));
            chk("pid_err", 32'(eop_pid_err), 32'd0);
            chk("eop_len", 32'(eop_len), 32'(len));
            chk("crc5_ok", 32'(eop_crc5_ok), 32'(exp_c5));
            if (nb != 1) chk("crc16_ok", 32'(eop_crc16_ok), 32'(exp_c16));
            chk("align_err", 32'(eop_align_err), 32'(partial != 0));
            chk("overflow", 32'(eop_overflow), 32'(ovf));
            chk("toolong", 32'(eop_toolong), 32'(tl));
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int j = 0; j < n; j++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, acc);
    endtask

    initial begin
        int nb, mode, ab, part, ra;
        #1;
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_eop_valid", 32'(eop_valid), 32'd0);
        chk("reset_eop_len", 32'(eop_len), 32'd0);
        chk("reset_eop_pid", 32'(eop_pid), 32'd0);
        chk("reset_flags", 32'({eop_crc5_ok, eop_crc16_ok, eop_pid_err, eop_align_err,
                                eop_overflow, eop_toolong}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        ready_pct = 100; send_packet(2, 1, 1'b0, -1, 0, 1'b0, -1);  idle(6);   // token, good CRC5
        ready_pct = 0;   send_packet(4, 2, 1'b0, -1, 0, 1'b0, -1);  idle(2);   // full FIFO, CRC16
        ready_pct = 100; idle(8);
        ready_pct = 100; send_packet(3, 0, 1'b1, -1, 0, 1'b0, -1);  idle(4);   // bad PID
        ready_pct = 0;   send_packet(6, 2, 1'b0, -1, 0, 1'b0, -1);  idle(2);   // overflow
        ready_pct = 100; idle(8);
        ready_pct = 100; send_packet(11, 2, 1'b0, -1, 0, 1'b0, -1); idle(8);   // too long
        ready_pct = 100; send_packet(2, 0, 1'b0, -1, 3, 1'b0, -1);  idle(4);   // partial byte
        ready_pct = 100; send_packet(2, 1, 1'b0, 5, 0, 1'b0, -1);   idle(4);   // SE0 in PID
        ready_pct = 0;   send_packet(6, 0, 1'b0, -1, 0, 1'b0, 19);  idle(2);   // reset mid-DATA
        ready_pct = 100; send_packet(2, 1, 1'b0, -1, 0, 1'b0, -1);  idle(6);

        for (int p = 0; p < 80; p++) begin
            nb   = $urandom_range(0, 11);
            mode = $urandom_range(0, 2);
            ab   = ($urandom_range(14) == 0) ? $urandom_range(0, 7) : -1;
            part = ($urandom_range(3) == 0) ? $urandom_range(1, 7) : 0;
            ra   = ($urandom_range(19) == 0 && (8 * nb + part) > 0) ?
                   $urandom_range(0, 8 * nb + part - 1) : -1;
            case ($urandom_range(3))
                0:       ready_pct = 0;
                1:       ready_pct = 30;
                2:       ready_pct = 70;
                default: ready_pct = 100;
            endcase
            send_packet(nb, mode, ($urandom_range(9) == 0), ab, part,
                        ($urandom_range(4) == 0), ra);
            ready_pct = $urandom_range(0, 100);
            idle($urandom_range(1, 6));
        end
        ready_pct = 100;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
